// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lends one UART transmitter to N message FSMs for
// whole messages, with a per-byte watchdog that reclaims the bus from a stalled owner.
module uart_tx_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 65535,
   parameter int TW      = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   // requester done pulses ("release" is a reserved word)
   input  logic [N-1:0]   rel,
   input  logic [N-1:0]   ld_in,
   input  logic [8*N-1:0] data_in,
   input  logic           txempty_in,
   output logic [7:0]     txdata_out,
   output logic           ldtxdata_out,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   txempty_out,
   output logic           busy,
   output logic           timeout_err
);

   // state   | meaning
   // S_IDLE  | no owner, pick next requester round-robin after ptr
   // S_GRANT | requester g owns the transmitter until rel[g] or watchdog expiry
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [0:0]    state;
   logic [IW-1:0] g;
   logic [IW-1:0] ptr;
   logic [IW-1:0] win;
   logic [IW-1:0] idx;
   logic          any_req;
   logic [TW-1:0] wdog;
   logic [7:0]    bytes [N];
   logic          cur_ld;
   logic          cur_rel;
   logic          at_limit;

   for (genvar i = 0; i < N; i++) begin : g_bytes
      assign bytes[i] = data_in[8*i +: 8];
   end

   always_comb begin
      win     = '0;
      idx     = '0;
      any_req = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            win     = idx;
         end
      end
   end

   assign cur_ld   = ld_in[g];
   assign cur_rel  = rel[g];
   assign at_limit = (wdog == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         gnt         <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         wdog        <= '0;
         ptr         <= IW'(N - 1);
         g           <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  state <= S_GRANT;
                  g     <= win;
                  gnt   <= N'(1) << win;
                  busy  <= 1'b1;
                  wdog  <= '0;
               end
            end
            S_GRANT: begin
               // a genuine release on the expiry cycle suppresses the error pulse
               if (cur_rel || (!cur_ld && at_limit)) begin
                  state       <= S_IDLE;
                  gnt         <= '0;
                  busy        <= 1'b0;
                  ptr         <= g;
                  wdog        <= '0;
                  timeout_err <= !cur_rel;
               end else if (cur_ld) begin
                  wdog <= '0;
               end else if (wdog != '1) begin
                  wdog <= wdog + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      txdata_out   = '0;
      ldtxdata_out = 1'b0;
      txempty_out  = '0;
      if (!reset && state == S_GRANT) begin
         txdata_out     = bytes[g];
         ldtxdata_out   = ld_in[g];
         txempty_out[g] = txempty_in;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run against
// a message-level ownership model.
module tb_uart_tx_arbiter;
   localparam int N       = 4;
   localparam int TIMEOUT = 20;
   localparam int TW      = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req, rel, ld_in;
   logic [8*N-1:0] data_in;
   logic           txempty_in;
   logic [7:0]     txdata_out;
   logic           ldtxdata_out;
   logic [N-1:0]   gnt, txempty_out;
   logic           busy, timeout_err;

   int checks   = 0;
   int failures = 0;

   uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk(clk), .reset(reset), .req(req), .rel(rel), .ld_in(ld_in),
      .data_in(data_in), .txempty_in(txempty_in), .txdata_out(txdata_out),
      .ldtxdata_out(ldtxdata_out), .gnt(gnt), .txempty_out(txempty_out),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      req = '0; rel = '0; ld_in = '0; data_in = '0; txempty_in = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   function automatic logic bit_of(input logic [N-1:0] v, input int i);
      logic [N-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   task automatic test_reset;
      reset = 1'b1;
      req = '1; rel = '0; ld_in = '1; data_in = '1; txempty_in = 1'b1;
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_regs got gnt=%b busy=%b terr=%b exp 0000/0/0", gnt, busy, timeout_err);
      end
      checks++;
      if (txdata_out !== 8'h00 || ldtxdata_out !== 1'b0 || txempty_out !== 4'b0000) begin
         failures++;
         $display("FAIL reset_comb got data=%h ld=%b te=%b exp 00/0/0000", txdata_out, ldtxdata_out, txempty_out);
      end
      clear_inputs();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_single;
      req = 4'b0001;
      tick();
      checks++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_grant got gnt=%b busy=%b exp 0001/1", gnt, busy);
      end
      ld_in = 4'b0001; data_in = 32'h0000_0047; txempty_in = 1'b1;
      #1;
      checks++;
      if (txdata_out !== 8'h47 || ldtxdata_out !== 1'b1 || txempty_out !== 4'b0001) begin
         failures++;
         $display("FAIL single_mux got data=%h ld=%b te=%b exp 47/1/0001", txdata_out, ldtxdata_out, txempty_out);
      end
      tick();
      ld_in = '0; txempty_in = 1'b0; rel = 4'b0001; req = '0;
      #1;
      checks++;
      if (txempty_out !== 4'b0000) begin
         failures++;
         $display("FAIL single_txempty_low got %b exp 0000", txempty_out);
      end
      tick();
      rel = '0;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_release got gnt=%b busy=%b exp 0000/0", gnt, busy);
      end
   endtask

   task automatic test_round_robin;
      logic [N-1:0] order [5];
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;
      do_reset();
      req = '1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (gnt !== order[i]) begin
            failures++;
            $display("FAIL rr_grant_%0d got %b exp %b", i, gnt, order[i]);
         end
         ld_in = order[i];
         tick();
         tick();
         ld_in = '0; rel = order[i];
         tick();
         rel = '0;
         checks++;
         if (gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_gap_%0d got gnt=%b busy=%b exp 0000/0", i, gnt, busy);
         end
      end
      req = '0;
      tick();
   endtask

   task automatic test_isolation;
      req = 4'b0110;
      tick();
      req = '0;
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL iso_grant got %b exp 0010", gnt);
      end
      data_in = 32'h00FF_5A00; ld_in = 4'b0100; rel = 4'b0100; txempty_in = 1'b1;
      #1;
      checks++;
      if (txdata_out !== 8'h5A || ldtxdata_out !== 1'b0 || txempty_out !== 4'b0010) begin
         failures++;
         $display("FAIL iso_mux got data=%h ld=%b te=%b exp 5a/0/0010", txdata_out, ldtxdata_out, txempty_out);
      end
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL iso_hold got %b exp 0010", gnt);
      end
      ld_in = '0; rel = 4'b0010; txempty_in = 1'b0;
      tick();
      rel = '0;
      checks++;
      if (gnt !== 4'b0000) begin
         failures++;
         $display("FAIL iso_release got %b exp 0000", gnt);
      end
   endtask

   task automatic test_watchdog;
      int bad;
      req = 4'b1000;
      tick();
      req = '0;
      checks++;
      if (gnt !== 4'b1000) begin
         failures++;
         $display("FAIL wd_grant got %b exp 1000", gnt);
      end
      repeat (TIMEOUT - 1) tick();
      checks++;
      if (gnt !== 4'b1000 || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL wd_early got gnt=%b terr=%b exp 1000/0", gnt, timeout_err);
      end
      tick();
      checks++;
      if (gnt !== 4'b0000 || timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL wd_expire got gnt=%b terr=%b exp 0000/1", gnt, timeout_err);
      end
      tick();
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL wd_pulse_width got terr=%b exp 0", timeout_err);
      end
      req = 4'b1000;
      tick();
      req = '0;
      bad = 0;
      for (int b = 0; b < 10; b++) begin
         repeat (TIMEOUT - 2) begin
            tick();
            if (timeout_err !== 1'b0 || gnt !== 4'b1000) bad++;
         end
         ld_in = 4'b1000;
         tick();
         ld_in = '0;
         if (timeout_err !== 1'b0 || gnt !== 4'b1000) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL wd_fed got bad_cycles=%0d exp 0", bad);
      end
      rel = 4'b1000;
      tick();
      rel = '0;
   endtask

   task automatic test_simultaneous;
      req = 4'b0001;
      tick();
      req = '0;
      ld_in = 4'b0001; rel = 4'b0001; data_in = 32'h0000_0033;
      #1;
      checks++;
      if (txdata_out !== 8'h33 || ldtxdata_out !== 1'b1) begin
         failures++;
         $display("FAIL sim_forward got data=%h ld=%b exp 33/1", txdata_out, ldtxdata_out);
      end
      tick();
      ld_in = '0; rel = '0;
      checks++;
      if (gnt !== 4'b0000) begin
         failures++;
         $display("FAIL sim_release got %b exp 0000", gnt);
      end
      req = 4'b0001;
      tick();
      req = '0;
      repeat (TIMEOUT - 1) tick();
      rel = 4'b0001;
      tick();
      rel = '0;
      checks++;
      if (gnt !== 4'b0000 || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL sim_rel_on_timeout got gnt=%b terr=%b exp 0000/0", gnt, timeout_err);
      end
      tick();
      checks++;
      if (timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL sim_rel_on_timeout_after got terr=%b exp 0", timeout_err);
      end
   endtask

   task automatic test_reset_mid;
      req = 4'b0010;
      tick();
      req = '0;
      ld_in = 4'b0010; data_in = 32'h0000_AB00; txempty_in = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0010 || ldtxdata_out !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_pre got gnt=%b ld=%b exp 0010/1", gnt, ldtxdata_out);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || ldtxdata_out !== 1'b0 || txempty_out !== 4'b0000) begin
         failures++;
         $display("FAIL rstmid_async got gnt=%b busy=%b ld=%b te=%b exp 0000/0/0/0000",
                  gnt, busy, ldtxdata_out, txempty_out);
      end
      tick();
      reset = 1'b0;
      clear_inputs();
      req = 4'b0110;
      tick();
      req = '0;
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL rstmid_first got %b exp 0010", gnt);
      end
      rel = 4'b0010;
      tick();
      rel = '0;
   endtask

   task automatic test_random;
      int owner, mptr, quiet, nxt;
      logic exp_terr;
      logic [N-1:0] exp_gnt, exp_te;
      logic [8*N-1:0] sh;
      logic [7:0] exp_data;
      logic exp_ld;
      bit sparse;
      do_reset();
      owner = -1; mptr = N - 1; quiet = 0; sparse = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) sparse = ~sparse;
         req        = N'($urandom);
         ld_in      = sparse ? ((($urandom_range(0, 39)) == 0) ? N'($urandom) : '0) : N'($urandom);
         rel        = ($urandom_range(0, 30) == 0) ? N'($urandom) : '0;
         data_in    = (8*N)'($urandom);
         txempty_in = 1'($urandom);
         #1;
         if (owner < 0) begin
            exp_data = 8'h00; exp_ld = 1'b0; exp_te = '0;
         end else begin
            sh = data_in >> (8 * owner);
            exp_data = sh[7:0];
            exp_ld = bit_of(ld_in, owner);
            exp_te = N'(txempty_in) << owner;
         end
         checks++;
         if (txdata_out !== exp_data || ldtxdata_out !== exp_ld || txempty_out !== exp_te) begin
            failures++;
            $display("FAIL rand_mux c=%0d got data=%h ld=%b te=%b exp %h/%b/%b",
                     c, txdata_out, ldtxdata_out, txempty_out, exp_data, exp_ld, exp_te);
         end
         exp_terr = 1'b0;
         if (owner < 0) begin
            nxt = -1;
            for (int k = 1; k <= N; k++)
               if (nxt < 0 && bit_of(req, (mptr + k) % N)) nxt = (mptr + k) % N;
            if (nxt >= 0) begin
               owner = nxt;
               quiet = 0;
            end
         end else if (bit_of(rel, owner)) begin
            mptr = owner; owner = -1;
         end else if (bit_of(ld_in, owner)) begin
            quiet = 0;
         end else if (quiet + 1 == TIMEOUT) begin
            mptr = owner; owner = -1; exp_terr = 1'b1;
         end else begin
            quiet++;
         end
         tick();
         exp_gnt = (owner < 0) ? '0 : (N'(1) << owner);
         checks++;
         if (gnt !== exp_gnt || busy !== (owner >= 0) || timeout_err !== exp_terr) begin
            failures++;
            $display("FAIL rand_state c=%0d got gnt=%b busy=%b terr=%b exp %b/%b/%b",
                     c, gnt, busy, timeout_err, exp_gnt, (owner >= 0), exp_terr);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      test_reset();
      test_single();
      test_round_robin();
      test_isolation();
      test_watchdog();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
